// File: rtl/p_cacheline_responder_pkg.sv
// rtl/p_cacheline_responder_pkg.sv - shared line/beat widths and responder state type
// Imported by the interface, the line buffer and the responder top.
package p_cacheline_responder_pkg;

  localparam int S_OFFSET  = 5;
  localparam int S_LINE    = 256;
  localparam int S_BURST   = 64;
  localparam int NUM_BEATS = S_LINE / S_BURST;
  localparam int BEAT_W    = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_READ,
    RESP_WRITE,
    RESP_DONE
  } pmem_resp_state_t;

  // Zero the byte-offset bits so memory always sees a line-aligned address.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    logic [31:0] mask;
    mask              = '1;
    mask[S_OFFSET-1:0] = '0;
    return addr & mask;
  endfunction

endpackage

// File: rtl/p_cacheline_responder_if.sv
// rtl/p_cacheline_responder_if.sv - cache-side line interface and memory-side burst interface
// master is the requesting side on each bus; the responder is slave on the line bus, master on the burst bus.
interface p_cacheline_responder_if;
  import p_cacheline_responder_pkg::*;

  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [S_LINE-1:0] pmem_wdata;
  logic [S_LINE-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

interface p_cacheline_burst_if;
  import p_cacheline_responder_pkg::*;

  logic [31:0]        burst_address;
  logic               burst_read;
  logic               burst_write;
  logic [S_BURST-1:0] burst_wdata;
  logic [S_BURST-1:0] burst_rdata;
  logic               burst_resp;

  modport master (
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport slave (
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/p_cacheline_responder_line_beat_buffer.sv
// rtl/p_cacheline_responder_line_beat_buffer.sv - line storage with per-beat read assembly and beat select
// Read and write lines are kept apart so a write burst never disturbs the last returned read line.
module p_cacheline_responder_line_beat_buffer
  import p_cacheline_responder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_load,
  input  logic [S_LINE-1:0]  i_wr_line,
  input  logic               i_rd_load,
  input  logic [BEAT_W-1:0]  i_rd_idx,
  input  logic [S_BURST-1:0] i_rd_beat,
  input  logic [BEAT_W-1:0]  i_sel_idx,
  output logic [S_LINE-1:0]  o_rd_line,
  output logic [S_BURST-1:0] o_sel_beat
);

  logic [S_LINE-1:0] r_wr_line;
  logic [S_LINE-1:0] r_rd_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_line <= '0;
      r_rd_line <= '0;
    end else begin
      if (i_wr_load) begin
        r_wr_line <= i_wr_line;
      end
      if (i_rd_load) begin
        r_rd_line[i_rd_idx*S_BURST +: S_BURST] <= i_rd_beat;
      end
    end
  end

  assign o_rd_line  = r_rd_line;
  assign o_sel_beat = r_wr_line[i_sel_idx*S_BURST +: S_BURST];

endmodule

// File: rtl/p_cacheline_responder.sv
// rtl/p_cacheline_responder.sv - converts 256-bit line requests into 4 x 64-bit memory bursts
// FSM and beat counter live here; line storage is in the line_beat_buffer sub-module.
module p_cacheline_responder
  import p_cacheline_responder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  p_cacheline_responder_if.slave   line_if,
  p_cacheline_burst_if.master      burst_if
);

  pmem_resp_state_t   r_state;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [31:0]        r_address;
  logic               r_burst_read;
  logic               r_burst_write;
  logic [S_BURST-1:0] r_burst_wdata;
  logic               r_pmem_resp;

  logic               w_last_beat;
  logic [BEAT_W-1:0]  w_next_cnt;
  logic               w_rd_load;
  logic               w_wr_load;
  logic [S_BURST-1:0] w_sel_beat;
  logic [S_LINE-1:0]  w_rd_line;

  assign w_last_beat = (r_beat_cnt == BEAT_W'(NUM_BEATS - 1));
  assign w_next_cnt  = r_beat_cnt + 1'b1;
  assign w_rd_load   = (r_state == RESP_READ) && burst_if.burst_resp;
  // Read has priority, so the write line is only captured when no read is pending.
  assign w_wr_load   = (r_state == RESP_IDLE) && !line_if.pmem_read && line_if.pmem_write;

  p_cacheline_responder_line_beat_buffer u_line_beat_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_load  (w_wr_load),
    .i_wr_line  (line_if.pmem_wdata),
    .i_rd_load  (w_rd_load),
    .i_rd_idx   (r_beat_cnt),
    .i_rd_beat  (burst_if.burst_rdata),
    .i_sel_idx  (w_next_cnt),
    .o_rd_line  (w_rd_line),
    .o_sel_beat (w_sel_beat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RESP_IDLE;
      r_beat_cnt    <= '0;
      r_address     <= '0;
      r_burst_read  <= 1'b0;
      r_burst_write <= 1'b0;
      r_burst_wdata <= '0;
      r_pmem_resp   <= 1'b0;
    end else begin
      case (r_state)
        RESP_IDLE: begin
          if (line_if.pmem_read) begin
            r_address    <= line_align(line_if.pmem_address);
            r_burst_read <= 1'b1;
            r_beat_cnt   <= '0;
            r_state      <= RESP_READ;
          end else if (line_if.pmem_write) begin
            r_address     <= line_align(line_if.pmem_address);
            r_burst_write <= 1'b1;
            r_burst_wdata <= line_if.pmem_wdata[S_BURST-1:0];
            r_beat_cnt    <= '0;
            r_state       <= RESP_WRITE;
          end
        end
        RESP_READ: begin
          if (burst_if.burst_resp) begin
            if (w_last_beat) begin
              r_burst_read <= 1'b0;
              r_pmem_resp  <= 1'b1;
              r_beat_cnt   <= '0;
              r_state      <= RESP_DONE;
            end else begin
              r_beat_cnt <= w_next_cnt;
            end
          end
        end
        RESP_WRITE: begin
          // Next beat is staged on the accepting edge so burst_wdata stays registered.
          if (burst_if.burst_resp) begin
            if (w_last_beat) begin
              r_burst_write <= 1'b0;
              r_pmem_resp   <= 1'b1;
              r_beat_cnt    <= '0;
              r_state       <= RESP_DONE;
            end else begin
              r_beat_cnt    <= w_next_cnt;
              r_burst_wdata <= w_sel_beat;
            end
          end
        end
        RESP_DONE: begin
          r_pmem_resp <= 1'b0;
          r_state     <= RESP_IDLE;
        end
        default: begin
          r_state <= RESP_IDLE;
        end
      endcase
    end
  end

  assign line_if.pmem_rdata     = w_rd_line;
  assign line_if.pmem_resp      = r_pmem_resp;
  assign burst_if.burst_address = r_address;
  assign burst_if.burst_read    = r_burst_read;
  assign burst_if.burst_write   = r_burst_write;
  assign burst_if.burst_wdata   = r_burst_wdata;

endmodule

// File: tb/tb_p_cacheline_responder.sv
// tb/tb_p_cacheline_responder.sv - randomized scoreboard bench for the cacheline responder
// Driver queues expected lines, a memory model serves beats, a monitor pops on each pmem_resp.
module tb_p_cacheline_responder;
  import p_cacheline_responder_pkg::*;

  typedef struct {
    bit           is_write;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  p_cacheline_responder_if u_line_if ();
  p_cacheline_burst_if     u_burst_if ();

  p_cacheline_responder u_dut (
    .clk      (clk),
    .rst      (rst),
    .line_if  (u_line_if.slave),
    .burst_if (u_burst_if.master)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_resp_cyc = -1;
  int mem_beat = 0;
  bit contig = 1'b0;
  bit stray = 1'b0;
  logic [255:0] last_rd_line = '0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [63:0] mem_data(input logic [31:0] line_addr, input int beat);
    return {line_addr ^ 32'hA5A5_0000 ^ 32'(beat), ~line_addr + 32'(beat) * 32'h1111_1111};
  endfunction

  function automatic logic [255:0] read_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 4; i++) l[i*64 +: 64] = mem_data(align(a), i);
    return l;
  endfunction

  // Memory model: serves beats for the transaction at the head of the scoreboard queue.
  initial begin
    u_burst_if.burst_resp  = 1'b0;
    u_burst_if.burst_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_beat = 0;
        u_burst_if.burst_resp = 1'b0;
      end else begin
        u_burst_if.burst_resp = 1'b0;
        if (u_burst_if.burst_read || u_burst_if.burst_write) begin
          if (contig || ($urandom_range(0, 2) != 0)) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL mem_unexpected_burst act=%0b exp=0", u_burst_if.burst_read);
            end else begin
              exp_t e;
              logic [255:0] l;
              e = exp_q[0];
              l = e.line;
              check("burst_address", 256'(u_burst_if.burst_address), 256'(align(e.addr)));
              check("burst_dir", 256'(u_burst_if.burst_write), 256'(e.is_write));
              if (e.is_write)
                check("burst_wdata", 256'(u_burst_if.burst_wdata), 256'(l[mem_beat*64 +: 64]));
              else
                u_burst_if.burst_rdata = mem_data(align(e.addr), mem_beat);
            end
            u_burst_if.burst_resp = 1'b1;
            if (mem_beat == 3) exp_resp_cyc = cyc + 1;
            mem_beat = (mem_beat + 1) % 4;
          end
        end else if (stray) begin
          u_burst_if.burst_resp  = 1'b1;
          u_burst_if.burst_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: every completion pulse retires the oldest expected transaction.
  initial begin
    bit prev_resp;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_resp = 1'b0;
      end else begin
        if (u_line_if.pmem_resp) begin
          check("resp_single_cycle", 256'(prev_resp), 256'(0));
          check("resp_latency", 256'(cyc), 256'(exp_resp_cyc));
          check("burst_idle_at_resp", 256'(u_burst_if.burst_read | u_burst_if.burst_write), 256'(0));
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp act=1 exp=0");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.is_write) begin
              check("pmem_rdata", u_line_if.pmem_rdata, e.line);
              last_rd_line = e.line;
            end
          end
        end
        prev_resp = u_line_if.pmem_resp;
      end
    end
  end

  // op: 0 read, 1 write, 2 read+write held together.
  task automatic do_txn(input int op, input logic [31:0] addr, input logic [255:0] wline,
                        input bit scramble, output int lat, output logic [31:0] first_addr);
    exp_t e;
    int n_resp;
    int seen;
    int waited;
    int t0;
    n_resp = (op == 2) ? 2 : 1;
    seen = 0;
    waited = 0;
    lat = -1;
    first_addr = '0;
    if (op != 1) begin
      e.is_write = 1'b0; e.addr = addr; e.line = read_line(addr);
      exp_q.push_back(e);
    end
    if (op != 0) begin
      e.is_write = 1'b1; e.addr = addr; e.line = wline;
      exp_q.push_back(e);
    end
    @(negedge clk);
    u_line_if.pmem_address = addr;
    u_line_if.pmem_wdata   = wline;
    u_line_if.pmem_read    = (op != 1);
    u_line_if.pmem_write   = (op != 0);
    t0 = cyc;
    while (seen < n_resp && waited < 400) begin
      @(negedge clk);
      waited++;
      if (waited == 1) begin
        check("req_latency", 256'(u_burst_if.burst_read | u_burst_if.burst_write), 256'(1));
        first_addr = u_burst_if.burst_address;
      end
      if (u_line_if.pmem_resp) begin
        seen++;
        if (seen == 1) lat = cyc - t0;
        u_line_if.pmem_read = 1'b0;
        if (!(seen == 1 && op == 2)) u_line_if.pmem_write = 1'b0;
      end else if (scramble) begin
        u_line_if.pmem_address = $urandom;
        u_line_if.pmem_wdata   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
    if (seen < n_resp) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout act=%0d exp=%0d", seen, n_resp);
      u_line_if.pmem_read  = 1'b0;
      u_line_if.pmem_write = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin
    int lat;
    logic [31:0] fa;
    logic [255:0] wl;
    u_line_if.pmem_address = '0;
    u_line_if.pmem_read    = 1'b0;
    u_line_if.pmem_write   = 1'b0;
    u_line_if.pmem_wdata   = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pmem_resp", 256'(u_line_if.pmem_resp), 256'(0));
    check("rst_burst_read", 256'(u_burst_if.burst_read), 256'(0));
    check("rst_burst_write", 256'(u_burst_if.burst_write), 256'(0));
    check("rst_burst_address", 256'(u_burst_if.burst_address), 256'(0));
    check("rst_burst_wdata", 256'(u_burst_if.burst_wdata), 256'(0));
    check("rst_pmem_rdata", u_line_if.pmem_rdata, 256'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Contiguous read: memory answers every cycle from the first burst cycle.
    contig = 1'b1;
    do_txn(0, 32'h0000_1234, '0, 1'b0, lat, fa);
    check("contig_addr", 256'(fa), 256'(32'h0000_1220));
    check("contig_latency", 256'(lat), 256'(5));

    wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_txn(1, 32'h8000_0040, wl, 1'b0, lat, fa);
    check("write_addr", 256'(fa), 256'(32'h8000_0040));

    contig = 1'b0;
    do_txn(2, 32'h0000_5678, {8{$urandom}}, 1'b0, lat, fa);

    // Stray memory strobes while idle must leave everything untouched.
    stray = 1'b1;
    repeat (4) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_rdata", u_line_if.pmem_rdata, last_rd_line);
    check("stray_burst", 256'({u_burst_if.burst_read, u_burst_if.burst_write, u_line_if.pmem_resp}), 256'(0));

    // Reset in the middle of a read after two beats have been accepted.
    contig = 1'b1;
    begin
      exp_t e;
      int w;
      e.is_write = 1'b0; e.addr = 32'h0000_9A00; e.line = read_line(32'h0000_9A00);
      exp_q.push_back(e);
      @(negedge clk);
      u_line_if.pmem_address = 32'h0000_9A00;
      u_line_if.pmem_read    = 1'b1;
      w = 0;
      while (mem_beat != 2 && w < 50) begin
        @(negedge clk); #1; w++;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst_burst_read", 256'(u_burst_if.burst_read), 256'(0));
      check("midrst_pmem_resp", 256'(u_line_if.pmem_resp), 256'(0));
      check("midrst_pmem_rdata", u_line_if.pmem_rdata, 256'(0));
      u_line_if.pmem_read = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      last_rd_line = '0;
    end
    contig = 1'b0;
    do_txn(0, 32'h0000_9A1C, '0, 1'b1, lat, fa);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 2);
      do_txn(op, $urandom,
             {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             (op != 2), lat, fa);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
